// File: rtl/mod_addsub_pipe_pkg.sv
// Shared types and the single-step modular correction used by the
// mod_addsub_pipe datapath.
package mod_arith_pkg;

    // Lane datapath width; the lane sub-module is built at this width.
    localparam int MOD_W     = 32;
    localparam int MOD_LANES = 4;

    typedef enum logic {
        MOD_ADD = 1'b0,
        MOD_SUB = 1'b1
    } mod_op_e;

    // S1 lane record: widened raw sum/difference plus the operand range flag.
    typedef struct packed {
        logic [MOD_W:0] sum;
        logic           err;
    } s1_lane_t;

    // One correction step: subtract Q once after an add that reached Q,
    // add Q once after a subtract that borrowed. Not a full modulo for
    // out-of-range operands.
    function automatic logic [MOD_W-1:0] mod_correct(
        input logic [MOD_W:0]   s,
        input logic [MOD_W-1:0] q,
        input mod_op_e          op
    );
        logic [MOD_W:0] r;
        r = s;
        if (op == MOD_ADD) begin
            if (s >= {1'b0, q}) r = s - {1'b0, q};
        end else begin
            if (s[MOD_W]) r = s + {1'b0, q};
        end
        return r[MOD_W-1:0];
    endfunction

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Streaming bus of the modular add/sub pipeline.
//
// Handshake: an input beat transfers on a cycle where iValid & oReady.
// An output beat transfers on a cycle where oValid & iReady & iEn; while
// oValid is high and the beat has not transferred, oData/oRangeErr/oValid
// hold. iEn=0 freezes both sides; iClr drops everything in flight and
// forces oReady low for that cycle.
interface mod_addsub_pipe_if #(
    parameter int BITWIDTH = 32,
    parameter int LANES    = 4
);
    logic                      iEn;
    logic                      iClr;
    logic                      iValid;
    logic                      oReady;
    logic                      iSub;
    logic [BITWIDTH-1:0]       iQ;
    logic [LANES*BITWIDTH-1:0] iData0;
    logic [LANES*BITWIDTH-1:0] iData1;
    logic                      oValid;
    logic                      iReady;
    logic [LANES*BITWIDTH-1:0] oData;
    logic [LANES-1:0]          oRangeErr;

    // Source/sink side (drives the i* signals).
    modport master (
        output iEn, iClr, iValid, iSub, iQ, iData0, iData1, iReady,
        input  oReady, oValid, oData, oRangeErr
    );

    // The pipeline itself.
    modport slave (
        input  iEn, iClr, iValid, iSub, iQ, iData0, iData1, iReady,
        output oReady, oValid, oData, oRangeErr
    );
endinterface

// File: rtl/mod_addsub_pipe_lane.sv
// One lane of the modular add/sub pipeline: S1 raw add/sub with range flag,
// S2 single-step correction. Load enables come from the top-level handshake;
// this module holds no valid state.
module mod_addsub_lane
    import mod_arith_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ld1,
    input  logic             i_ld2,
    input  mod_op_e          i_op,
    input  logic [MOD_W-1:0] i_q,
    input  logic [MOD_W-1:0] i_a,
    input  logic [MOD_W-1:0] i_b,
    input  mod_op_e          i_op1,
    input  logic [MOD_W-1:0] i_q1,
    output logic [MOD_W-1:0] o_data,
    output logic             o_err
);
    s1_lane_t         w_s1_next;
    s1_lane_t         r_s1;
    logic [MOD_W-1:0] r_data;
    logic             r_err;

    // Widened add/sub keeps the carry or borrow in the MSB.
    always_comb begin
        w_s1_next     = '0;
        w_s1_next.sum = (i_op == MOD_ADD) ? ({1'b0, i_a} + {1'b0, i_b})
                                          : ({1'b0, i_a} - {1'b0, i_b});
        w_s1_next.err = (i_a >= i_q) | (i_b >= i_q);
    end

    // S1 register: captures the raw result on input accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_s1 <= '0;
        else if (i_ld1) r_s1 <= w_s1_next;
    end

    // S2 register: corrected result and range flag presented on the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (i_ld2) begin
            r_data <= mod_correct(r_s1.sum, i_q1, i_op1);
            r_err  <= r_s1.err;
        end
    end

    assign o_data = r_data;
    assign o_err  = r_err;
endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage multi-lane modular adder/subtractor with valid/ready handshake.
// The top owns the stage valids, flush and the per-beat Q/mode that all
// lanes share; lane datapaths live in mod_addsub_lane.
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int BITWIDTH = MOD_W,
    parameter int LANES    = MOD_LANES
) (
    input  logic               iClk,
    input  logic               iRstN,
    mod_addsub_pipe_if.slave   bus
);
    logic                      r_v1;
    logic                      r_v2;
    logic [BITWIDTH-1:0]       r_q1;
    mod_op_e                   r_op1;
    logic                      w_adv2;
    logic                      w_acc;
    logic                      w_ld2;
    mod_op_e                   w_op;
    logic [LANES*BITWIDTH-1:0] w_data;
    logic [LANES-1:0]          w_err;

    // Handshake: S2 can move when empty or drained; S1 takes a beat when it
    // is empty or S2 is taking its contents. A flush cycle refuses input.
    assign w_adv2     = bus.iEn & (~r_v2 | bus.iReady);
    assign bus.oReady = bus.iEn & ~bus.iClr & (~r_v1 | w_adv2);
    assign w_acc      = bus.iValid & bus.oReady;
    // S2 data is left untouched on a flush so oData keeps its last value.
    assign w_ld2      = w_adv2 & ~bus.iClr;
    assign w_op       = bus.iSub ? MOD_SUB : MOD_ADD;

    // Stage valid bits; flush wins over accept and enable.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (bus.iClr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv2) r_v2 <= r_v1;
            if (w_acc)       r_v1 <= 1'b1;
            else if (w_adv2) r_v1 <= 1'b0;
        end
    end

    // Modulus and mode travel with the beat into S1 for the S2 correction.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_q1  <= '0;
            r_op1 <= MOD_ADD;
        end else if (w_acc) begin
            r_q1  <= bus.iQ;
            r_op1 <= w_op;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mod_addsub_lane u_lane (
            .i_clk   (iClk),
            .i_rst_n (iRstN),
            .i_ld1   (w_acc),
            .i_ld2   (w_ld2),
            .i_op    (w_op),
            .i_q     (bus.iQ),
            .i_a     (bus.iData0[g*BITWIDTH +: BITWIDTH]),
            .i_b     (bus.iData1[g*BITWIDTH +: BITWIDTH]),
            .i_op1   (r_op1),
            .i_q1    (r_q1),
            .o_data  (w_data[g*BITWIDTH +: BITWIDTH]),
            .o_err   (w_err[g])
        );
    end

    assign bus.oValid    = r_v2;
    assign bus.oData     = w_data;
    assign bus.oRangeErr = w_err;
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Bench for mod_addsub_pipe: directed scenarios plus a randomized stream
// checked in order against an arithmetic reference model.
module tb_mod_addsub_pipe;
    localparam int W = 32;
    localparam int L = 4;
    localparam logic [W-1:0] Q_BIG = 32'hFFFF_FFFB;

    typedef logic [L+L*W-1:0] beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    mod_addsub_pipe_if #(.BITWIDTH(W), .LANES(L)) bus ();

    mod_addsub_pipe #(.BITWIDTH(W), .LANES(L)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus)
    );

    // Reference: true modular arithmetic on 64-bit integers.
    function automatic logic [W-1:0] ref_lane(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] q, input logic sub);
        logic [63:0] sa, sb, sq, r;
        sa = {32'b0, a};
        sb = {32'b0, b};
        sq = {32'b0, q};
        r  = sub ? ((sa + sq - sb) % sq) : ((sa + sb) % sq);
        return r[W-1:0];
    endfunction

    function automatic beat_t ref_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                       input logic [W-1:0] q, input logic sub);
        logic [L*W-1:0] d;
        logic [L-1:0]   e;
        for (int k = 0; k < L; k++) begin
            d[k*W +: W] = ref_lane(a[k*W +: W], b[k*W +: W], q, sub);
            e[k]        = (a[k*W +: W] >= q) || (b[k*W +: W] >= q);
        end
        return {e, d};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iEn    = 1'b1;
        bus.iClr   = 1'b0;
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        bus.iSub   = 1'b0;
        bus.iQ     = 32'd23;
        bus.iData0 = '0;
        bus.iData1 = '0;
    endtask

    // Send one beat into an empty pipe with iReady=1 and check latency and result.
    task automatic run_beat(input string name, input logic sub, input logic [W-1:0] q,
                            input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                            output beat_t got);
        beat_t exp;
        exp        = ref_beat(a, b, q, sub);
        bus.iEn    = 1'b1;
        bus.iReady = 1'b1;
        bus.iValid = 1'b1;
        bus.iSub   = sub;
        bus.iQ     = q;
        bus.iData0 = a;
        bus.iData1 = b;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b expected 1", name, bus.oReady);
        end
        next_cycle();
        bus.iValid = 1'b0;
        #1;
        checks++;
        if (bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_valid: got %b expected 0", name, bus.oValid);
        end
        next_cycle();
        #1;
        got = {bus.oRangeErr, bus.oData};
        checks++;
        if (bus.oValid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: got %b expected 1", name, bus.oValid);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, got, exp);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oData !== '0 || bus.oRangeErr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b expected 0", bus.oValid, bus.oData, bus.oRangeErr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", bus.oReady);
        end
    endtask

    task automatic test_add_basic();
        beat_t got;
        run_beat("add23", 1'b0, 32'd23, {32'd17, 32'd5, 32'd0, 32'd22},
                 {32'd3, 32'd10, 32'd0, 32'd22}, got);
        checks++;
        if (got[W-1:0] !== 32'd21 || got[2*W-1:W] !== 32'd0) begin
            errors++;
            $display("FAIL add23_lanes: got %0d,%0d expected 21,0", got[W-1:0], got[2*W-1:W]);
        end
    endtask

    task automatic test_sub_basic();
        beat_t got;
        run_beat("sub23", 1'b1, 32'd23, {32'd22, 32'd0, 32'd7, 32'd5},
                 {32'd0, 32'd22, 32'd5, 32'd7}, got);
        checks++;
        if (got[W-1:0] !== 32'd21 || got[2*W-1:W] !== 32'd2 || got[L*W +: L] !== 4'b0000) begin
            errors++;
            $display("FAIL sub23_lanes: got %0d,%0d err=%b expected 21,2 err=0000",
                     got[W-1:0], got[2*W-1:W], got[L*W +: L]);
        end
    endtask

    task automatic test_carry();
        beat_t got;
        logic [W-1:0] qm1;
        qm1 = Q_BIG - 32'd1;
        run_beat("carry_add", 1'b0, Q_BIG, {L{qm1}}, {L{qm1}}, got);
        checks++;
        if (got[W-1:0] !== Q_BIG - 32'd2) begin
            errors++;
            $display("FAIL carry_add_lane0: got %h expected %h", got[W-1:0], Q_BIG - 32'd2);
        end
        run_beat("borrow_sub", 1'b1, Q_BIG, '0, {L{qm1}}, got);
        checks++;
        if (got[W-1:0] !== 32'd1) begin
            errors++;
            $display("FAIL borrow_sub_lane0: got %h expected 1", got[W-1:0]);
        end
    endtask

    task automatic test_random_stream();
        int    sent = 0;
        int    recv = 0;
        int    cyc  = 0;
        logic  prev_hold = 1'b0;
        beat_t prev_beat = '0;
        beat_t exp;
        logic [L*W-1:0] a, b;
        exp_q.delete();
        idle();
        while (recv < 100 && cyc < 3000) begin
            bus.iEn    = !(cyc >= 40 && cyc < 43);
            bus.iReady = 1'($urandom_range(0, 1));
            if (sent < 100) begin
                for (int k = 0; k < L; k++) begin
                    a[k*W +: W] = $urandom_range(0, 22);
                    b[k*W +: W] = $urandom_range(0, 22);
                end
                bus.iValid = ($urandom_range(0, 3) != 0);
                bus.iSub   = 1'($urandom_range(0, 1));
                bus.iData0 = a;
                bus.iData1 = b;
            end else begin
                bus.iValid = 1'b0;
            end
            #1;
            if (!bus.iEn) begin
                checks++;
                if (bus.oReady !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_en_ready: cycle %0d got %b expected 0", cyc, bus.oReady);
                end
            end
            if (prev_hold) begin
                checks++;
                if (bus.oValid !== 1'b1 || {bus.oRangeErr, bus.oData} !== prev_beat) begin
                    errors++;
                    $display("FAIL rand_hold: cycle %0d got v=%b %h expected v=1 %h",
                             cyc, bus.oValid, {bus.oRangeErr, bus.oData}, prev_beat);
                end
            end
            if (bus.iValid && bus.oReady) begin
                exp_q.push_back(ref_beat(bus.iData0, bus.iData1, bus.iQ, bus.iSub));
                sent++;
            end
            if (bus.oValid && bus.iReady && bus.iEn) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_beat: cycle %0d got %h expected none",
                             cyc, {bus.oRangeErr, bus.oData});
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.oRangeErr, bus.oData} !== exp) begin
                        errors++;
                        $display("FAIL rand_data: beat %0d got %h expected %h",
                                 recv, {bus.oRangeErr, bus.oData}, exp);
                    end
                end
                recv++;
            end
            prev_hold = bus.oValid && !(bus.iReady && bus.iEn);
            prev_beat = {bus.oRangeErr, bus.oData};
            next_cycle();
            cyc++;
        end
        checks++;
        if (recv != 100 || sent != 100) begin
            errors++;
            $display("FAIL rand_count: got sent=%0d recv=%0d expected 100/100", sent, recv);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_leftover: got %0d queued expected 0", exp_q.size());
        end
        idle();
        bus.iClr = 1'b1;
        next_cycle();
        bus.iClr = 1'b0;
    endtask

    task automatic test_clear();
        beat_t got;
        idle();
        bus.iReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.iValid = 1'b1;
            bus.iData0 = {L{32'd3 + 32'(i)}};
            bus.iData1 = {L{32'd4}};
            #1;
            checks++;
            if (bus.oReady !== 1'b1) begin
                errors++;
                $display("FAIL clr_fill_ready%0d: got %b expected 1", i, bus.oReady);
            end
            next_cycle();
        end
        #1;
        checks++;
        if (bus.oReady !== 1'b0 || bus.oValid !== 1'b1) begin
            errors++;
            $display("FAIL clr_full: got rdy=%b v=%b expected rdy=0 v=1", bus.oReady, bus.oValid);
        end
        bus.iClr = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready_during: got %b expected 0", bus.oReady);
        end
        next_cycle();
        bus.iClr   = 1'b0;
        bus.iValid = 1'b0;
        #1;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL clr_after: got v=%b rdy=%b expected v=0 rdy=1", bus.oValid, bus.oReady);
        end
        run_beat("clr_next", 1'b0, 32'd23, {L{32'd1}}, {L{32'd1}}, got);
        checks++;
        if (got[W-1:0] !== 32'd2) begin
            errors++;
            $display("FAIL clr_next_lane0: got %0d expected 2", got[W-1:0]);
        end
        #1;
        checks++;
        if (bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_stale: got %b expected 0", bus.oValid);
        end
    endtask

    task automatic test_range_and_reset();
        beat_t got;
        idle();
        run_beat("range", 1'b0, 32'd23, {32'd1, 32'd1, 32'd1, 32'd23},
                 {32'd2, 32'd2, 32'd2, 32'd0}, got);
        checks++;
        if (got[L*W +: L] !== 4'b0001 || got[W-1:0] !== 32'd0) begin
            errors++;
            $display("FAIL range_err: got err=%b lane0=%0d expected err=0001 lane0=0",
                     got[L*W +: L], got[W-1:0]);
        end
        bus.iReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.iValid = 1'b1;
            bus.iData0 = {L{32'd9}};
            bus.iData1 = {L{32'd30}};
            next_cycle();
        end
        bus.iValid = 1'b0;
        #1;
        checks++;
        if (bus.oValid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid: got %b expected 1", bus.oValid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oData !== '0 || bus.oRangeErr !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b d=%h e=%b expected 0", bus.oValid, bus.oData, bus.oRangeErr);
        end
        bus.iReady = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            checks++;
            if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1) begin
                errors++;
                $display("FAIL rst_release%0d: got v=%b rdy=%b expected v=0 rdy=1",
                         i, bus.oValid, bus.oReady);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub_basic();
        test_carry();
        test_random_stream();
        test_clear();
        test_range_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
